// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } lsu_state_e;

    typedef struct packed {
        logic       valid;
        logic [2:0] funct3;
        logic [1:0] off;
        logic       err;
        logic       we;
    } rsp_stg_t;

    // Illegal funct3 for the direction, or an access not aligned to its own size.
    function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic bad_f3;
        bad_f3 = we ? !(f3 inside {F3_B, F3_H, F3_W})
                    : !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        return bad_f3 || ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bus between the MEM stage and the load/store unit.
interface dmem_lsu_if #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  init_done;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, init_done
    );
endinterface

// File: rtl/dmem_byte_ram.sv
// Single-port word RAM with four byte lanes, synchronous read and byte-enable write.
module dmem_byte_ram #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7
) (
    input  logic          clk,
    input  logic [AW-1:0] i_addr,
    input  logic [3:0]    i_be,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [3:0][7:0] r_mem [DEPTH];

    // Read returns the pre-write contents when the same word is written in the same cycle.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_be[b]) r_mem[i_addr][b] <= i_wdata[8*b +: 8];
        end
        o_rdata <= r_mem[i_addr];
    end
endmodule

// File: rtl/dmem_lsu.sv
// RV32 MEM-stage load/store unit: byte-lane RAM, lane align/extend, error reporting, post-reset clear.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter bit          INIT_ZERO  = 1'b1
) (
    input  logic      clk,
    input  logic      reset,
    dmem_lsu_if.slave bus
);
    localparam int unsigned WORD_W = DM_ADDRESS - 2;
    localparam int unsigned DEPTH  = 1 << WORD_W;

    if (DATA_W != 32) begin : g_bad_data_w
        $error("dmem_lsu: DATA_W must be 32");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("dmem_lsu: RD_LAT must be in 1..4");
    end

    lsu_state_e         r_state;
    logic [WORD_W-1:0]  r_clr_cnt;
    logic               r_ready;
    logic               r_init_done;
    rsp_stg_t           r_stg [RD_LAT];

    logic               w_accept;
    logic               w_err;
    logic [1:0]         w_off;
    logic [3:0]         w_be;
    logic [DATA_W-1:0]  w_lane_wdata;
    logic [WORD_W-1:0]  w_ram_addr;
    logic [3:0]         w_ram_be;
    logic [DATA_W-1:0]  w_ram_wdata;
    logic [DATA_W-1:0]  w_ram_rdata;
    logic [DATA_W-1:0]  w_last_data;
    rsp_stg_t           w_stg_in;
    rsp_stg_t           w_last;
    logic [DATA_W-1:0]  w_lane;
    logic [DATA_W-1:0]  w_ext;

    // Control FSM: clear one word per cycle after reset, then accept requests forever.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= INIT_ZERO ? ST_INIT : ST_RUN;
            r_clr_cnt   <= '0;
            r_ready     <= 1'b0;
            r_init_done <= INIT_ZERO ? 1'b0 : 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == WORD_W'(DEPTH - 1)) begin
                        r_state     <= ST_RUN;
                        r_ready     <= 1'b1;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    r_ready     <= 1'b1;
                    r_init_done <= 1'b1;
                end
            endcase
        end
    end

    // Request decode and the shared RAM port mux (clear address wins during INIT).
    always_comb begin
        w_accept     = bus.req_valid & r_ready;
        w_off        = bus.req_addr[1:0];
        w_err        = req_illegal(bus.req_we, bus.req_funct3, w_off);
        w_be         = 4'b0000;
        w_lane_wdata = '0;
        case (bus.req_funct3[1:0])
            2'b00: begin
                w_be         = 4'b0001 << w_off;
                w_lane_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_be         = 4'b0011 << w_off;
                w_lane_wdata = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                w_be         = 4'b1111;
                w_lane_wdata = bus.req_wdata;
            end
            default: ;
        endcase
        if (r_state == ST_INIT) begin
            w_ram_addr  = r_clr_cnt;
            w_ram_be    = 4'b1111;
            w_ram_wdata = '0;
        end else begin
            w_ram_addr  = bus.req_addr[DM_ADDRESS-1:2];
            w_ram_be    = (w_accept && bus.req_we && !w_err) ? w_be : 4'b0000;
            w_ram_wdata = w_lane_wdata;
        end
        w_stg_in = '{valid: w_accept, funct3: bus.req_funct3, off: w_off, err: w_err, we: bus.req_we};
    end

    dmem_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (WORD_W)
    ) u_ram (
        .clk     (clk),
        .i_addr  (w_ram_addr),
        .i_be    (w_ram_be),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Response tags travel alongside the read data; reset drops anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) r_stg[i] <= '0;
        end else begin
            r_stg[0] <= w_stg_in;
            for (int i = 1; i < RD_LAT; i++) r_stg[i] <= r_stg[i-1];
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign w_last_data = w_ram_rdata;
    end else begin : g_latn
        logic [DATA_W-1:0] r_dat [RD_LAT-1];
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < RD_LAT - 1; i++) r_dat[i] <= '0;
            end else begin
                r_dat[0] <= w_ram_rdata;
                for (int i = 1; i < RD_LAT - 1; i++) r_dat[i] <= r_dat[i-1];
            end
        end
        assign w_last_data = r_dat[RD_LAT-2];
    end

    // Lane select and sign/zero extension at the final stage.
    always_comb begin
        w_last = r_stg[RD_LAT-1];
        w_lane = w_last_data >> {w_last.off, 3'b000};
        w_ext  = '0;
        case (w_last.funct3)
            F3_B:    w_ext = {{(DATA_W-8){w_lane[7]}}, w_lane[7:0]};
            F3_H:    w_ext = {{(DATA_W-16){w_lane[15]}}, w_lane[15:0]};
            F3_W:    w_ext = w_lane;
            F3_BU:   w_ext = {{(DATA_W-8){1'b0}}, w_lane[7:0]};
            F3_HU:   w_ext = {{(DATA_W-16){1'b0}}, w_lane[15:0]};
            default: w_ext = '0;
        endcase
    end

    assign bus.req_ready = r_ready;
    assign bus.init_done = r_init_done;
    assign bus.rsp_valid = w_last.valid;
    assign bus.rsp_err   = w_last.valid & w_last.err;
    assign bus.rsp_rdata = (w_last.valid && !w_last.err && !w_last.we) ? w_ext : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: byte-level reference model, two latencies in lockstep, reset cases.
module tb_dmem_lsu;
    import dmem_pkg::*;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned LAT_A = 1;
    localparam int unsigned LAT_B = 3;

    typedef struct {
        int unsigned cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ab;
    logic        rst_0;
    logic        s_valid, s0_valid, s_we;
    logic [2:0]  s_f3;
    logic [8:0]  s_addr;
    logic [31:0] s_wdata;

    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        q_a[$];
    exp_t        q_b[$];
    exp_t        ea, eb;
    logic [7:0]  mem_m [DEPTH*4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_lsu_if #(.DM_ADDRESS(9), .DATA_W(32)) bus_a ();
    dmem_lsu_if #(.DM_ADDRESS(9), .DATA_W(32)) bus_b ();
    dmem_lsu_if #(.DM_ADDRESS(9), .DATA_W(32)) bus_0 ();

    assign bus_a.req_valid = s_valid;   assign bus_b.req_valid = s_valid;   assign bus_0.req_valid = s0_valid;
    assign bus_a.req_we = s_we;         assign bus_b.req_we = s_we;         assign bus_0.req_we = s_we;
    assign bus_a.req_funct3 = s_f3;     assign bus_b.req_funct3 = s_f3;     assign bus_0.req_funct3 = s_f3;
    assign bus_a.req_addr = s_addr;     assign bus_b.req_addr = s_addr;     assign bus_0.req_addr = s_addr;
    assign bus_a.req_wdata = s_wdata;   assign bus_b.req_wdata = s_wdata;   assign bus_0.req_wdata = s_wdata;

    dmem_lsu #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(LAT_A), .INIT_ZERO(1'b1))
        u_dut_a (.clk(clk), .reset(rst_ab), .bus(bus_a.slave));
    dmem_lsu #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(LAT_B), .INIT_ZERO(1'b1))
        u_dut_b (.clk(clk), .reset(rst_ab), .bus(bus_b.slave));
    dmem_lsu #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(2), .INIT_ZERO(1'b0))
        u_dut_0 (.clk(clk), .reset(rst_0), .bus(bus_0.slave));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-addressed memory model: legality, store side effect and extended load value.
    task automatic model(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                         input logic [31:0] wdata, output exp_t e);
        int          nb;
        logic        legal;
        logic [31:0] v;
        nb    = 1 << f3[1:0];
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if ((int'(addr) % nb) != 0) legal = 1'b0;
        e.err   = !legal;
        e.rdata = '0;
        e.cyc   = 0;
        if (legal && we) begin
            for (int k = 0; k < nb; k++) mem_m[int'(addr) + k] = wdata[8*k +: 8];
        end else if (legal) begin
            v = '0;
            for (int k = 0; k < nb; k++) v = v | (32'(mem_m[int'(addr) + k]) << (8*k));
            if (!f3[2] && nb < 4 && mem_m[int'(addr) + nb - 1][7]) v = v | (32'hFFFF_FFFF << (8*nb));
            e.rdata = v;
        end
    endtask

    // Drive one request for one cycle on both lockstep DUTs and queue what each must return.
    task automatic send(input logic we, input logic [2:0] f3, input logic [8:0] addr, input logic [31:0] wdata);
        exp_t e;
        model(we, f3, addr, wdata, e);
        s_valid = 1'b1; s_we = we; s_f3 = f3; s_addr = addr; s_wdata = wdata;
        e.cyc = cyc + LAT_A; q_a.push_back(e);
        e.cyc = cyc + LAT_B; q_b.push_back(e);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_ab) begin
            if (bus_a.rsp_valid) begin
                if (q_a.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL a_unexpected: got rsp_valid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    ea = q_a.pop_front();
                    check("a_rdata", bus_a.rsp_rdata, ea.rdata);
                    check("a_err", 32'(bus_a.rsp_err), 32'(ea.err));
                    check("a_cycle", cyc, ea.cyc);
                end
            end else if (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
                ea = q_a.pop_front();
                check("a_missing_rsp", 32'(bus_a.rsp_valid), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_ab) begin
            if (bus_b.rsp_valid) begin
                if (q_b.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL b_unexpected: got rsp_valid=1 expected no response (cycle %0d)", cyc);
                end else begin
                    eb = q_b.pop_front();
                    check("b_rdata", bus_b.rsp_rdata, eb.rdata);
                    check("b_err", 32'(bus_b.rsp_err), 32'(eb.err));
                    check("b_cycle", cyc, eb.cyc);
                end
            end else if (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
                eb = q_b.pop_front();
                check("b_missing_rsp", 32'(bus_b.rsp_valid), 32'd1);
            end
        end
    end

    initial begin
        int          n;
        int          pulses;
        logic        we;
        logic [2:0]  f3;
        logic [8:0]  addr;

        rst_ab = 1'b1; rst_0 = 1'b1;
        s_valid = 1'b0; s0_valid = 1'b0; s_we = 1'b0; s_f3 = '0; s_addr = '0; s_wdata = '0;
        for (int i = 0; i < DEPTH*4; i++) mem_m[i] = 8'h00;

        // Start a clear, then hit reset partway through it.
        repeat (3) @(posedge clk);
        #1 rst_ab = 1'b0;
        repeat (40) @(posedge clk);
        #1 rst_ab = 1'b1;
        #1;
        check("rst_ready", 32'(bus_a.req_ready), 32'd0);
        check("rst_init_done", 32'(bus_a.init_done), 32'd0);
        check("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus_a.rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(bus_a.rsp_err), 32'd0);
        check("rst0_ready", 32'(bus_0.req_ready), 32'd0);
        check("rst0_init_done", 32'(bus_0.init_done), 32'd1);
        @(posedge clk); #1 rst_ab = 1'b0;

        // A store held on the bus during the clear must be ignored.
        s_valid = 1'b1; s_we = 1'b1; s_f3 = F3_W; s_addr = 9'h1FC; s_wdata = 32'hDEAD_BEEF;
        n = 0;
        while (!bus_a.req_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        s_valid = 1'b0;
        check("init_ready_low_cycles", 32'(n), 32'(DEPTH));
        check("init_done_a", 32'(bus_a.init_done), 32'd1);
        check("init_done_b", 32'(bus_b.init_done), 32'd1);
        check("ready_b", 32'(bus_b.req_ready), 32'd1);

        send(1'b0, F3_W, 9'h1FC, 32'h0);
        send(1'b0, F3_W, 9'h0A8, 32'h0);

        // Sign/zero extension on one stored word.
        send(1'b1, F3_W, 9'h010, 32'h8000_80F1);
        send(1'b0, F3_B, 9'h010, 32'h0);
        send(1'b0, F3_BU, 9'h011, 32'h0);
        send(1'b0, F3_H, 9'h012, 32'h0);
        send(1'b0, F3_HU, 9'h012, 32'h0);

        // Partial stores merging into one word.
        send(1'b1, F3_W, 9'h020, 32'h0);
        send(1'b1, F3_B, 9'h023, 32'h0000_00AB);
        send(1'b1, F3_H, 9'h020, 32'h0000_1234);
        send(1'b0, F3_W, 9'h020, 32'h0);

        // Misaligned and illegal requests leave word 0x04 alone.
        send(1'b1, F3_W, 9'h004, 32'hCAFE_F00D);
        send(1'b1, F3_H, 9'h005, 32'h0000_FFFF);
        send(1'b1, F3_W, 9'h006, 32'h1111_1111);
        send(1'b0, F3_W, 9'h001, 32'h0);
        send(1'b0, 3'b011, 9'h004, 32'h0);
        send(1'b1, 3'b100, 9'h004, 32'h2222_2222);
        send(1'b0, F3_W, 9'h004, 32'h0);

        // Store immediately followed by a load to the same word.
        send(1'b1, F3_W, 9'h040, 32'h0000_0055);
        send(1'b0, F3_W, 9'h040, 32'h0);

        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 8) begin
                if (we) f3 = 3'($urandom_range(0, 2));
                else    f3 = (3'($urandom_range(0, 4)) > 3'd2) ? 3'($urandom_range(4, 5)) : 3'($urandom_range(0, 2));
            end
            addr = 9'($urandom);
            if ($urandom_range(0, 1) == 1) addr[8:5] = 4'h0;
            if ($urandom_range(0, 9) < 8) addr = addr & ~9'((1 << f3[1:0]) - 1);
            send(we, f3, addr, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (8) @(posedge clk);
        #1;
        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);

        // No clear: ready on the first edge after release; reset flushes in-flight loads.
        rst_0 = 1'b0;
        @(posedge clk); #1;
        check("noinit_ready", 32'(bus_0.req_ready), 32'd1);
        check("noinit_done", 32'(bus_0.init_done), 32'd1);
        s0_valid = 1'b1; s_we = 1'b0; s_f3 = F3_W; s_addr = 9'h000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s0_valid = 1'b0;
        check("noinit_first_rsp", 32'(bus_0.rsp_valid), 32'd1);
        rst_0 = 1'b1;
        #1;
        check("noinit_async_drop", 32'(bus_0.rsp_valid), 32'd0);
        @(posedge clk); #1 rst_0 = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_0.rsp_valid) pulses++;
        end
        check("noinit_flushed_rsp", 32'(pulses), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
